// File: rtl/fifo_pkg.sv
// Shared types and pointer helpers for the asynchronous FIFO controllers.
// Gray/binary helpers work on any pointer up to PTR_MAX_W bits (zero-extended).
package fifo_pkg;

    localparam int PTR_MAX_W = 32;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } wr_state_t;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        for (int i = 0; i < PTR_MAX_W; i++) b[i] = ^(g >> i);
        return b;
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into this clock domain.
module fifo_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_pipe;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_pipe <= '0;
        else          r_pipe <= {r_pipe[STAGES-2:0], i_d};
    end

    assign o_q = r_pipe[STAGES-1];

endmodule

// File: rtl/fifo_write_ctrl.sv
// Write-domain controller of the async FIFO: write strobe/address, Gray write
// pointer, full/almost-full/free-count flags, sticky overflow and a settling flush.
module fifo_write_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = 2,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  w_clk,
    input  logic                  wresetn,
    input  logic                  wr_enable,
    input  logic                  flush,
    input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
    output logic                  fifo_wr_enable,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH:0]   wr_ptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   free_count,
    output logic                  overflow,
    output logic                  flush_busy
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam int CW = $clog2(SYNC_STAGES + 2);
    localparam logic [PW-1:0] DEPTH_P = PW'(depth_of(ADDR_WIDTH));
    localparam logic [PW-1:0] THRESH  = PW'(AFULL_THRESH);
    localparam logic [CW-1:0] SETTLE  = CW'(SYNC_STAGES + 1);

    wr_state_t     r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [PW-1:0] r_wbin, r_wgray, r_free;
    logic [PW-1:0] w_wbin_next, w_wgray_next, w_rq, w_rbin_s, w_fill, w_free_next;
    logic          r_full, r_afull, r_ovf;
    logic          w_busy, w_accept, w_refused, w_full_next;

    fifo_sync #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_rptr_sync (
        .i_clk   (w_clk),
        .i_rst_n (wresetn),
        .i_d     (rd_ptr_gray),
        .o_q     (w_rq)
    );

    assign w_busy       = (r_state == FLUSH);
    assign w_accept     = wr_enable & ~r_full & ~flush & ~w_busy;
    assign w_refused    = wr_enable &  r_full & ~flush & ~w_busy;
    assign w_wbin_next  = r_wbin + PW'(w_accept);
    assign w_wgray_next = PW'(bin2gray(PTR_MAX_W'(w_wbin_next)));
    assign w_rbin_s     = PW'(gray2bin(PTR_MAX_W'(w_rq)));
    // Full when the writer is exactly one lap ahead: top two Gray bits differ.
    assign w_full_next  = (w_wgray_next == {~w_rq[PW-1:PW-2], w_rq[PW-3:0]});
    assign w_fill       = w_wbin_next - w_rbin_s;
    // A read pointer seemingly ahead of the writer (stale after flush) reads as no room.
    assign w_free_next  = (w_fill > DEPTH_P) ? '0 : DEPTH_P - w_fill;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            RUN: begin
                if (flush) begin
                    w_state_next = FLUSH;
                    w_cnt_next   = SETTLE;
                end
            end
            FLUSH: begin
                if (flush) begin
                    w_cnt_next = SETTLE;
                end else if (r_cnt <= CW'(1)) begin
                    w_state_next = RUN;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_next = RUN;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge w_clk or negedge wresetn) begin
        if (!wresetn) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_wbin  <= '0;
            r_wgray <= '0;
            r_ovf   <= 1'b0;
            r_full  <= 1'b0;
            r_afull <= 1'b0;
            r_free  <= DEPTH_P;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (!w_busy && flush) begin
                r_wbin  <= '0;
                r_wgray <= '0;
                r_ovf   <= 1'b0;
            end else begin
                r_wbin  <= w_wbin_next;
                r_wgray <= w_wgray_next;
                if (w_refused) r_ovf <= 1'b1;
            end
            // Flags are pinned while flushing and recomputed on the exit edge.
            if (w_state_next == FLUSH) begin
                r_full  <= 1'b1;
                r_afull <= 1'b1;
                r_free  <= '0;
            end else begin
                r_full  <= w_full_next;
                r_afull <= (w_free_next <= THRESH);
                r_free  <= w_free_next;
            end
        end
    end

    assign fifo_wr_enable = w_accept;
    assign wr_addr        = r_wbin[ADDR_WIDTH-1:0];
    assign wr_ptr_gray    = r_wgray;
    assign full           = r_full;
    assign almost_full    = r_afull;
    assign free_count     = r_free;
    assign overflow       = r_ovf;
    assign flush_busy     = w_busy;

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Self-checking bench for fifo_write_ctrl (ADDR_WIDTH=3, AFULL_THRESH=2, SYNC_STAGES=2).
module tb_fifo_write_ctrl;

    localparam int AW = 3;
    localparam int PW = 4;

    logic          w_clk = 1'b0;
    logic          wresetn = 1'b0;
    logic          wr_enable = 1'b0;
    logic          flush = 1'b0;
    logic [PW-1:0] rd_ptr_gray = '0;
    logic          fifo_wr_enable;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] wr_ptr_gray;
    logic          full, almost_full, overflow, flush_busy;
    logic [PW-1:0] free_count;

    int n_chk = 0;
    int n_pass = 0;

    always #5 w_clk = ~w_clk;

    fifo_write_ctrl #(.ADDR_WIDTH(AW), .AFULL_THRESH(2), .SYNC_STAGES(2)) dut (
        .w_clk          (w_clk),
        .wresetn        (wresetn),
        .wr_enable      (wr_enable),
        .flush          (flush),
        .rd_ptr_gray    (rd_ptr_gray),
        .fifo_wr_enable (fifo_wr_enable),
        .wr_addr        (wr_addr),
        .wr_ptr_gray    (wr_ptr_gray),
        .full           (full),
        .almost_full    (almost_full),
        .free_count     (free_count),
        .overflow       (overflow),
        .flush_busy     (flush_busy)
    );

    typedef struct {
        logic          wr, fl;
        logic [PW-1:0] rg;
        logic          e_stb;
        logic [AW-1:0] e_addr;
        logic          e_full, e_af;
        logic [PW-1:0] e_free;
        logic          e_ovf, e_busy;
        logic [PW-1:0] e_gray;
    } vec_t;

    vec_t tbl[23];
    vec_t sbq[$];

    function automatic logic [PW-1:0] gray(input int b);
        logic [PW-1:0] v;
        v = PW'(b);
        return v ^ (v >> 1);
    endfunction

    function automatic vec_t mk(input int wr, fl, rg, stb, addr, fu, af, fr, ov, bs, gr);
        vec_t v;
        v.wr = 1'(wr);      v.fl = 1'(fl);       v.rg = PW'(rg);
        v.e_stb = 1'(stb);  v.e_addr = AW'(addr);
        v.e_full = 1'(fu);  v.e_af = 1'(af);     v.e_free = PW'(fr);
        v.e_ovf = 1'(ov);   v.e_busy = 1'(bs);   v.e_gray = PW'(gr);
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic post(input string tag);
        vec_t e;
        if (sbq.size() == 0) begin
            n_chk++;
            $display("FAIL %s: scoreboard empty, got output, expected a queued entry", tag);
            return;
        end
        e = sbq.pop_front();
        chk({tag, " full"}, int'(full), int'(e.e_full));
        chk({tag, " afull"}, int'(almost_full), int'(e.e_af));
        chk({tag, " free"}, int'(free_count), int'(e.e_free));
        chk({tag, " ovf"}, int'(overflow), int'(e.e_ovf));
        chk({tag, " busy"}, int'(flush_busy), int'(e.e_busy));
        chk({tag, " gray"}, int'(wr_ptr_gray), int'(e.e_gray));
    endtask

    // Drive one cycle: check the combinational strobe/address before the edge,
    // queue the post-edge expectation, compare after the edge.
    task automatic step(input vec_t v, input string tag);
        wr_enable = v.wr;
        flush = v.fl;
        rd_ptr_gray = v.rg;
        #1;
        chk({tag, " stb"}, int'(fifo_wr_enable), int'(v.e_stb));
        chk({tag, " addr"}, int'(wr_addr), int'(v.e_addr));
        sbq.push_back(v);
        @(posedge w_clk);
        #1;
        post(tag);
    endtask

    task automatic do_reset();
        wr_enable = 1'b0;
        flush = 1'b0;
        rd_ptr_gray = '0;
        wresetn = 1'b0;
        @(posedge w_clk); #1;
        @(posedge w_clk); #1;
        wresetn = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " addr"}, int'(wr_addr), 0);
        chk({tag, " gray"}, int'(wr_ptr_gray), 0);
        chk({tag, " full"}, int'(full), 0);
        chk({tag, " afull"}, int'(almost_full), 0);
        chk({tag, " free"}, int'(free_count), 8);
        chk({tag, " ovf"}, int'(overflow), 0);
        chk({tag, " busy"}, int'(flush_busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;

        // Fill to full, overflow, drain via read pointer, refill, flush, resume.
        for (int i = 0; i < 8; i++)
            tbl[i] = mk(1, 0, 0, 1, i, (i == 7), (i >= 5), 7 - i, 0, 0, gray(i + 1));
        for (int i = 8; i < 11; i++)
            tbl[i] = mk(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 4'b1100);
        tbl[11] = mk(0, 0, 4'b0010, 0, 0, 1, 1, 0, 1, 0, 4'b1100);
        tbl[12] = mk(0, 0, 4'b0010, 0, 0, 1, 1, 0, 1, 0, 4'b1100);
        tbl[13] = mk(0, 0, 4'b0010, 0, 0, 0, 0, 3, 1, 0, 4'b1100);
        tbl[14] = mk(1, 0, 4'b0010, 1, 0, 0, 1, 2, 1, 0, 4'b1101);
        tbl[15] = mk(1, 0, 4'b0010, 1, 1, 0, 1, 1, 1, 0, 4'b1111);
        tbl[16] = mk(1, 0, 4'b0010, 1, 2, 1, 1, 0, 1, 0, 4'b1110);
        tbl[17] = mk(1, 0, 4'b0010, 0, 3, 1, 1, 0, 1, 0, 4'b1110);
        tbl[18] = mk(1, 1, 0,       0, 3, 1, 1, 0, 0, 1, 4'b0000);
        tbl[19] = mk(1, 0, 0,       0, 0, 1, 1, 0, 0, 1, 4'b0000);
        tbl[20] = mk(1, 0, 0,       0, 0, 1, 1, 0, 0, 1, 4'b0000);
        tbl[21] = mk(1, 0, 0,       0, 0, 0, 0, 8, 0, 0, 4'b0000);
        tbl[22] = mk(1, 0, 0,       1, 0, 0, 0, 7, 0, 0, 4'b0001);

        do_reset();
        chk_reset_vals("reset");
        chk("reset stb", int'(fifo_wr_enable), 0);

        for (int i = 0; i < 23; i++) step(tbl[i], $sformatf("row%0d", i));

        // Flush re-asserted during the settle window restarts it.
        wr_enable = 1'b0;
        flush = 1'b1;
        @(posedge w_clk); #1;
        chk("reflush enter busy", int'(flush_busy), 1);
        flush = 1'b0;
        @(posedge w_clk); #1;
        flush = 1'b1;
        @(posedge w_clk); #1;
        flush = 1'b0;
        chk("reflush reload busy", int'(flush_busy), 1);
        cyc = 0;
        while (flush_busy && cyc < 20) begin
            @(posedge w_clk); #1;
            cyc++;
        end
        chk("reflush window", cyc, 3);
        chk("reflush free", int'(free_count), 8);

        // Interleaved write/read across two pointer wraps; fill settles at 3.
        do_reset();
        for (int c = 0; c < 20; c++)
            step(mk(1, 0, gray(c), 1, c % 8, 0, 0, 8 - ((c + 1 < 3) ? c + 1 : 3), 0, 0, gray(c + 1)),
                 $sformatf("wrap%0d", c));

        // Asynchronous reset in the middle of a burst.
        do_reset();
        for (int i = 0; i < 5; i++)
            step(mk(1, 0, 0, 1, i, 0, 0, 7 - i, 0, 0, gray(i + 1)), $sformatf("burst%0d", i));
        chk("preRst free", int'(free_count), 3);
        #2 wresetn = 1'b0;
        #1;
        chk_reset_vals("midRst");
        @(posedge w_clk); #1;
        wresetn = 1'b1;
        step(mk(1, 0, 0, 1, 0, 0, 0, 7, 0, 0, 1), "resume");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_write_ctrl.md
# fifo_write_ctrl

Write-domain controller for the asynchronous FIFO, parametrised successor to the original write-pointer/full logic. It accepts write requests and issues the memory write strobe and address. It publishes a Gray-coded write pointer to the read domain and synchronises the read domain's Gray pointer internally. It also provides full, almost-full, free-slot count, a sticky overflow flag, and a sequenced flush with a settle window.

## Interface
Parameters:
- `ADDR_WIDTH`, 4: memory address bits. DEPTH = 2**ADDR_WIDTH. Pointers are ADDR_WIDTH+1 bits.
- `AFULL_THRESH`, 2: `almost_full` asserts when free slots <= AFULL_THRESH. Legal range is 1..DEPTH-1.
- `SYNC_STAGES`, 2: flop stages on `rd_ptr_gray`. Minimum is 2.

Ports:
- `w_clk` in 1: write clock. This is the only clock.
- `wresetn` in 1: reset, asynchronous assert, active-low.
- `wr_enable` in 1: write request. Each cycle it is high is one request.
- `flush` in 1: start flush. Level-sampled.
- `rd_ptr_gray` in ADDR_WIDTH+1: Gray-coded read pointer from the read domain. Asynchronous to `w_clk`.
- `fifo_wr_enable` out 1: memory write strobe. Combinational.
- `wr_addr` out ADDR_WIDTH: memory write address.
- `wr_ptr_gray` out ADDR_WIDTH+1: registered Gray-coded write pointer, sent to the read domain.
- `full` out 1: registered.
- `almost_full` out 1: registered.
- `free_count` out ADDR_WIDTH+1: registered. Range 0..DEPTH.
- `overflow` out 1: sticky. Set by a write request that is refused.
- `flush_busy` out 1: high while in the FLUSH state.

## Operation
- Internal state: binary write pointer `wbin` (ADDR_WIDTH+1 bits), `wr_ptr_gray` = bin2gray(`wbin`), and synchronised read pointer `rq` converted to binary `rbin_s`.
- `wr_addr` = `wbin[ADDR_WIDTH-1:0]`.
- `fifo_wr_enable` = `wr_enable & !full & !flush & !flush_busy`. A write request is accepted only when this is 1.
- Accepted write: `wbin` increments by 1, modulo 2**(ADDR_WIDTH+1). The MSB toggles on each wrap through the address space.
- Full rule: `full` is registered from the next Gray pointer. It is set when that pointer equals `rq` with its two MSBs inverted and all other bits equal.
- Fill and free count, evaluated on the next pointer:
  - fill = (`wbin_next` - `rbin_s`), unsigned, ADDR_WIDTH+1 bits.
  - `free_count` = DEPTH - fill.
  - `almost_full` = (`free_count` <= AFULL_THRESH).
- Overflow: if `wr_enable & full & !flush & !flush_busy`, then `overflow` <= 1. It holds until reset or flush. Refused requests do not move `wbin`.
- State machine with states RUN and FLUSH:
  - RUN -> FLUSH when `flush`=1. On that edge: `wbin`<=0, `wr_ptr_gray`<=0, `overflow`<=0, settle counter <= SYNC_STAGES+1.
  - In FLUSH: `flush_busy`=1, `full`=1, `almost_full`=1, `free_count`=0. Writes are refused and do not set `overflow`. The counter decrements each cycle. If `flush` is still high, the counter reloads.
  - FLUSH -> RUN when the counter reaches 0 and `flush`=0. Flags are recomputed from `rq` on the first RUN cycle.
- The read domain must flush its own pointer concurrently. The settle window lets `rq` reflect the zeroed read pointer.

## Timing
- Reset values: `wbin`=0, `wr_ptr_gray`=0, synchroniser flops=0, `full`=0, `almost_full`=0, `free_count`=DEPTH, `overflow`=0, `flush_busy`=0, state=RUN. `fifo_wr_enable` follows its equation.
- Reset asserted mid-operation: all outputs return to the reset values immediately, asynchronously.
- Accepted write at edge N:
  - `wr_addr` and `fifo_wr_enable` are valid before edge N.
  - `wbin`, `wr_ptr_gray`, `full`, `almost_full` and `free_count` update at edge N. Latency is 1 cycle.
- The DEPTH-th accepted write with no reads raises `full` on that same edge.
- Read-side pointer movement: visible in `rq` after SYNC_STAGES edges. Flags update on the following edge, so total is SYNC_STAGES+1. Flags are therefore pessimistic, never optimistic.
- Flush precedence: `flush` takes priority over a simultaneous `wr_enable`. The strobe is 0 in the flush cycle.
- `flush` while already in FLUSH: restarts the window.
- `free_count` never exceeds DEPTH and never underflows.

## Structure
- Package `fifo_pkg` holds:
  - functions `bin2gray` and `gray2bin`, parametrised by width;
  - enum `wr_state_t` {RUN, FLUSH};
  - localparam helpers for DEPTH.
- Sub-module `fifo_sync`: SYNC_STAGES-deep, WIDTH-wide flop chain on `w_clk`/`wresetn`. It is reused by the read-side controller.

## Test plan
Common setup: ADDR_WIDTH=3 (DEPTH 8), AFULL_THRESH=2, SYNC_STAGES=2.
1. Reset, then 8 consecutive writes with `rd_ptr_gray`=0 -> `wr_addr` 0..7; `almost_full`=1 after write 6; `full`=1 after write 8; `free_count`=0; `wr_ptr_gray`=4'b1100.
2. FIFO full, `wr_enable`=1 for 3 cycles -> `fifo_wr_enable`=0; `wbin` unchanged; `overflow`=1 and stays 1.
3. From full, drive `rd_ptr_gray`=gray(3)=4'b0010 -> `full` falls 3 cycles later; `free_count`=3; `almost_full`=0.
4. Wrap: write/read 20 entries interleaved -> MSB toggles at 8 and 16; no false `full`; `free_count` is correct each cycle.
5. `flush` together with `wr_enable` while `full` and `overflow`=1 -> strobe 0; next edge `wbin`=0, `overflow`=0, `flush_busy`=1 for 3 cycles with `full`=1; then RUN, `free_count`=8.
6. `wresetn` pulsed low mid-burst at `wbin`=5 -> all outputs return to reset values immediately; writing resumes at `wr_addr`=0.
